fifo_4096_ctrl: RTL and testbench
=================================

# fifo_4096_ctrl

Pointer-and-flag controller that drives the address/strobe side of the `fifo_4096` storage array. It turns a push/pop handshake into `write`/`read` strobes and `wr_address`/`rd_address` for the array, and passes data through. It sits between the producer/consumer logic and `fifo_4096`, which has no internal pointers. It tracks occupancy and reports full/empty status, almost-full/almost-empty status and optional error flags.

## Interface
- ADDR_WIDTH, 12, array address width; DEPTH = 2**ADDR_WIDTH = 4096
- DATA_WIDTH, 8, data width, equal to the `fifo_4096` data width
- AF_THRESH, 4092, almost_full asserted when count >= AF_THRESH
- AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- push  in  1  producer write request
- push_data  in  DATA_WIDTH  write data
- pop  in  1  consumer read request
- pop_data  out  DATA_WIDTH  read data, meaningful when pop_valid=1
- pop_valid  out  1  pop_data valid, one cycle after an accepted pop
- full, empty, almost_full, almost_empty  out  1 each  status flags
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags (see Configuration)
- write, read  out  1 each  array strobes
- wr_address, rd_address  out  ADDR_WIDTH  array addresses
- data_in  out  DATA_WIDTH  array write data, driven combinationally from push_data
- data_out  in  DATA_WIDTH  array read data, registered inside the array

## Operation
- Internal state: wr_ptr and rd_ptr (ADDR_WIDTH bits each, wrap modulo DEPTH), count register.
- Accept rules:
  - push_acc = push & ~full
  - pop_acc = pop & ~empty
- Decided boundary behaviour:
  - A push while full is dropped, even if pop is asserted in the same cycle.
  - A pop while empty is dropped, even if push is asserted in the same cycle. There is no fall-through path.
- Array drive (combinational):
  - write = push_acc, wr_address = wr_ptr
  - read = pop_acc, rd_address = rd_ptr
- Register updates on a clock edge without reset:
  - wr_ptr += push_acc
  - rd_ptr += pop_acc
  - count += push_acc − pop_acc, so a simultaneous accept leaves count unchanged
- Pointer wrap: 4095 → 0 with no special case.
- Flags are decoded from count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= AF_THRESH)
  - almost_empty = (count <= AE_THRESH)
- Read path:
  - pop_valid is registered as the pop_acc value from the previous cycle.
  - pop_data = data_out, passed through with no extra register.
- Error flags (when compiled in):
  - overflow sets on push & full.
  - underflow sets on pop & empty.
  - Both are sticky until reset.

## Timing
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0, pop_valid = 0, overflow = 0, underflow = 0
  - Resulting flags: empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - write and read are 0 during reset regardless of push/pop.
- Write latency: data is written on the same edge that accepts the push. count and flags update on that edge.
- Read latency: 1 cycle. A pop accepted at edge N gives pop_valid = 1 with the data after edge N+1.
- Back-to-back: one push and one pop per cycle, sustained indefinitely.
- Flag sequencing:
  - empty deasserts the cycle after the first accepted push, so the earliest pop is the cycle after that push.
  - full asserts the cycle after the 4096th push.
- Reset mid-operation:
  - Pointers and count return to 0 at that edge, and all stored contents are considered lost.
  - An in-flight pop_valid is cleared.
- Full and empty are mutually exclusive for DEPTH > 0.

## Configuration
- FIFO_CTRL_ERR_EN:
  - Defined: overflow and underflow registers are implemented as described in Operation.
  - Undefined: overflow and underflow are tied to 0, no registers are built, and accept/drop behaviour is unchanged.

## Test plan
- Reset and idle: assert reset for 2 cycles → count = 0, empty = 1, almost_empty = 1, full = 0, pop_valid = 0, write = 0, read = 0.
- Fill and drain:
  - Push 4096 incrementing words → full = 1 and count = 4096 after the last push, with almost_full asserted once count reaches 4092.
  - Then pop 4096 → values 0..4095 in order, each 1 cycle after its pop; empty = 1 at the end.
- Overflow/underflow:
  - Push while full → no write strobe, count stays 4096, overflow = 1 (with FIFO_CTRL_ERR_EN).
  - Pop while empty → no read strobe, underflow = 1.
  - Without the macro, both flags stay 0.
- Simultaneous:
  - At count = 10, push & pop for 100 cycles → count stays 10, wr_ptr and rd_ptr each advance 100, data stays in order.
  - push & pop when empty → only the push is accepted, count = 1, pop_valid stays 0.
- Wrap-around: preload 4000 words and drain 4000, then push/pop 200 more → wr_address passes 4095 → 0, and the data read back matches.
- Reset mid-operation: at count = 50 with a pop in flight, assert reset → next cycle pop_valid = 0, count = 0, wr_address = 0, rd_address = 0.

Source files
------------

// File: rtl/fifo_4096_ctrl.sv
// Pointer/flag controller for the pointer-less fifo_4096 storage array.
// Latency: write strobe same cycle as push; pop_valid/pop_data one cycle after an accepted pop.
// Backpressure: push dropped while full, pop dropped while empty (no fall-through).
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   push, push_data       producer side; accepted when not full
//   pop, pop_data,        consumer side; accepted when not empty,
//   pop_valid             data returns one cycle later with pop_valid
//   full, empty,          status decoded from the occupancy counter
//   almost_full,
//   almost_empty, count
//   overflow, underflow   sticky error flags (only with FIFO_CTRL_ERR_EN)
//   write, read,          array-side strobes and addresses
//   wr_address,
//   rd_address
//   data_in, data_out     array data; data_in mirrors push_data, data_out
//                         is registered inside the array
//
// Build option: define FIFO_CTRL_ERR_EN to implement the sticky
// overflow/underflow registers; otherwise both outputs are tied low.

module fifo_4096_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = 4092,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  write,
    output logic                  read,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pop_valid_q, pop_valid_d;

    logic push_acc;
    logic pop_acc;
    logic full_w;
    logic empty_w;

    // Flags come straight from the occupancy counter, so they change on the
    // same edge as count and never need separate state.
    always_comb begin
        full_w       = (count_q == DEPTH_C);
        empty_w      = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
    end

    assign full  = full_w;
    assign empty = empty_w;
    assign count = count_q;

    // Accept decisions use only the registered flags: a pop never sees a
    // word pushed in the same cycle, and a push never relies on a
    // same-cycle pop to make room. Reset masks both so the array is not
    // strobed while the controller is being cleared.
    always_comb begin
        push_acc = push & ~full_w  & ~reset;
        pop_acc  = pop  & ~empty_w & ~reset;
    end

    // Array drive
    assign write      = push_acc;
    assign read       = pop_acc;
    assign wr_address = wr_ptr_q;
    assign rd_address = rd_ptr_q;
    assign data_in    = push_data;

    // The array registers its read data on the accepting edge, so data_out
    // lines up with the registered pop_valid without another stage here.
    assign pop_data  = data_out;
    assign pop_valid = pop_valid_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;

        // Pointers wrap naturally at DEPTH since they are exactly ADDR_WIDTH wide.
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky: once a request is dropped the flag holds until reset.
    always_comb begin
        overflow_d  = overflow_q  | (push & full_w);
        underflow_d = underflow_q | (pop  & empty_w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_4096_ctrl.sv
// Bench for fifo_4096_ctrl: table-driven vectors plus multi-cycle sequences,
// with a behavioural model of the fifo_4096 array and a data scoreboard.
// Latency/backpressure expectations come from a small occupancy/pointer model.

module tb_fifo_4096_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4096;
    localparam int AF    = 4092;
    localparam int AE    = 4;

`ifdef FIFO_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b1;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b1;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          write, read;
    logic [AW-1:0] wr_address, rd_address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out = '0;

    fifo_4096_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow),
        .write(write), .read(read),
        .wr_address(wr_address), .rd_address(rd_address),
        .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Behavioural fifo_4096 array: synchronous write, registered read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (write) mem[wr_address] <= data_in;
        if (read)  data_out <= mem[rd_address];
    end

    // Wrap monitor on the write address stream
    bit      saw_wrap = 1'b0;
    int      last_wa = -1;
    always @(posedge clk) begin
        if (write) begin
            if (last_wa == DEPTH - 1 && wr_address == '0) saw_wrap = 1'b1;
            last_wa = int'(wr_address);
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    int            mcnt = 0;
    int            wptr = 0;
    int            rptr = 0;
    bit            movf = 1'b0;
    bit            munf = 1'b0;
    logic [DW-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input bit exp_pv);
        chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
        if (exp_pv) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard: got pop_data %0d, expected no data (queue empty)", pop_data);
            end else begin
                chk("pop_data", 32'(pop_data), 32'(sb.pop_front()));
            end
        end
        chk("count", 32'(count), mcnt);
        chk("full", 32'(full), 32'(mcnt == DEPTH));
        chk("empty", 32'(empty), 32'(mcnt == 0));
        chk("almost_full", 32'(almost_full), 32'(mcnt >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(mcnt <= AE));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(munf));
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit p, input bit q, input logic [DW-1:0] d,
                         output bit w_seen, output bit r_seen);
        bit pa, qa;
        pa = p && (mcnt != DEPTH);
        qa = q && (mcnt != 0);
        push = p;
        pop = q;
        push_data = d;
        #1;
        w_seen = write;
        r_seen = read;
        chk("write", 32'(write), 32'(pa));
        chk("read", 32'(read), 32'(qa));
        chk("wr_address", 32'(wr_address), wptr);
        chk("rd_address", 32'(rd_address), rptr);
        if (pa) chk("data_in", 32'(data_in), 32'(d));
        @(posedge clk);
        #1;
        if (ERR_EN && p && mcnt == DEPTH) movf = 1'b1;
        if (ERR_EN && q && mcnt == 0) munf = 1'b1;
        if (pa) begin
            sb.push_back(d);
            wptr = (wptr + 1) % DEPTH;
            mcnt++;
        end
        if (qa) begin
            rptr = (rptr + 1) % DEPTH;
            mcnt--;
        end
        push = 1'b0;
        pop = 1'b0;
        check_state(qa);
    endtask

    // Two reset cycles with push/pop held high; strobes must stay low.
    task automatic do_reset();
        reset = 1'b1;
        push = 1'b1;
        pop = 1'b1;
        push_data = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_write", 32'(write), 32'd0);
            chk("rst_read", 32'(read), 32'd0);
            chk("rst_pop_valid", 32'(pop_valid), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
        end
        reset = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        mcnt = 0;
        wptr = 0;
        rptr = 0;
        movf = 1'b0;
        munf = 1'b0;
        sb.delete();
        #1;
        check_state(1'b0);
        chk("rst_wr_address", 32'(wr_address), 32'd0);
        chk("rst_rd_address", 32'(rd_address), 32'd0);
        chk("rst_write_idle", 32'(write), 32'd0);
    endtask

    typedef struct {
        bit            p;
        bit            q;
        logic [DW-1:0] d;
        bit            ew;
        bit            er;
        int            ecnt;
        bit            epv;
    } vec_t;

    vec_t tv[12];

    initial begin
        bit ws, rs;

        //           push pop data   write read count pop_valid
        tv[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0};  // pop while empty
        tv[2]  = '{1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1, 1'b0};  // push+pop on empty
        tv[3]  = '{1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 2, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1, 1'b1};
        tv[5]  = '{1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 8'hD4, 1'b1, 1'b0, 2, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0};
        tv[10] = '{1'b1, 1'b0, 8'hE5, 1'b1, 1'b0, 1, 1'b0};
        tv[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0};

        // Reset and idle
        do_reset();

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            cycle(tv[i].p, tv[i].q, tv[i].d, ws, rs);
            chk($sformatf("tv%0d_write", i), 32'(ws), 32'(tv[i].ew));
            chk($sformatf("tv%0d_read", i), 32'(rs), 32'(tv[i].er));
            chk($sformatf("tv%0d_count", i), 32'(count), tv[i].ecnt);
            chk($sformatf("tv%0d_pop_valid", i), 32'(pop_valid), 32'(tv[i].epv));
        end
        chk("tv_underflow", 32'(underflow), 32'(ERR_EN));

        // Fill, overflow, drain, underflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, i[7:0], ws, rs);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4096);
        chk("fill_almost_full", 32'(almost_full), 32'd1);
        cycle(1'b1, 1'b0, 8'h55, ws, rs);
        chk("ovf_no_write", 32'(ws), 32'd0);
        chk("ovf_count", 32'(count), 32'd4096);
        chk("ovf_flag", 32'(overflow), 32'(ERR_EN));
        cycle(1'b1, 1'b1, 8'h66, ws, rs);
        chk("full_pushpop_write", 32'(ws), 32'd0);
        chk("full_pushpop_read", 32'(rs), 32'd1);
        chk("full_pushpop_count", 32'(count), 32'd4095);
        cycle(1'b1, 1'b0, 8'hAA, ws, rs);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, ws, rs);
        chk("drain_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b1, 8'h00, ws, rs);
        chk("unf_no_read", 32'(rs), 32'd0);
        chk("unf_flag", 32'(underflow), 32'(ERR_EN));

        // Simultaneous push/pop at count 10
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(i + 100), ws, rs);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 8'(i * 7 + 3), ws, rs);
        chk("sim_count", 32'(count), 32'd10);
        chk("sim_wr_address", 32'(wr_address), 32'd110);
        chk("sim_rd_address", 32'(rd_address), 32'd100);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, ws, rs);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 4000; i++) cycle(1'b1, 1'b0, 8'(i ^ 8'h5A), ws, rs);
        for (int i = 0; i < 4000; i++) cycle(1'b0, 1'b1, 8'h00, ws, rs);
        saw_wrap = 1'b0;
        for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0, 8'(i * 13 + 1), ws, rs);
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1, 8'h00, ws, rs);
        chk("wrap_seen", 32'(saw_wrap), 32'd1);
        chk("wrap_wr_address", 32'(wr_address), 32'd104);
        chk("wrap_rd_address", 32'(rd_address), 32'd104);

        // Reset with a pop in flight
        do_reset();
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 8'(i + 1), ws, rs);
        pop = 1'b1;
        push = 1'b0;
        #1;
        chk("mid_read", 32'(read), 32'd1);
        @(posedge clk);
        #1;
        pop = 1'b0;
        chk("mid_pop_valid_inflight", 32'(pop_valid), 32'd1);
        chk("mid_pop_data", 32'(pop_data), 32'd1);
        do_reset();
        chk("mid_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
